// File: rtl/norm_arbiter_pkg.sv
// Shared widths and result record for the normalizing arbiter.
package norm_arbiter_pkg;

  localparam int unsigned MAN_W = 27;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned LZ_W  = $clog2(MAN_W) + 1;

  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             src;
    logic             zero;
    logic             uf;
  } norm_res_t;

endpackage

// File: rtl/norm_arbiter_find_first_1.sv
// Leading-one detector: index of the highest set bit, all-ones when the input is zero.
module find_first_1 #(
  parameter int unsigned IN_WIDTH  = 27,
  parameter int unsigned OUT_WIDTH = $clog2(IN_WIDTH) + 1
) (
  input  logic [IN_WIDTH-1:0]  in_i,
  output logic [OUT_WIDTH-1:0] first_o
);

  always_comb begin
    first_o = '1;
    // Ascending scan so the highest set bit is the last assignment.
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (in_i[i]) first_o = OUT_WIDTH'(i);
    end
  end

endmodule

// File: rtl/norm_arbiter.sv
// Round-robin arbiter sharing one leading-one detector and normalizing shifter
// between the add/sub (port 0) and multiply (port 1) requesters.
module norm_arbiter
  import norm_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*MAN_W-1:0] req_man,
  input  logic [2*EXP_W-1:0] req_exp,
  input  logic [1:0]         req_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W-1:0]   out_man,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_sign,
  output logic               out_src,
  output logic               out_zero,
  output logic               out_uf
);

  logic             out_valid_q, out_valid_d;
  logic             last_grant_q, last_grant_d;
  norm_res_t        res_q, res_d;

  logic             stage_free;
  logic             grant;
  logic             accept;
  logic [MAN_W-1:0] sel_man;
  logic [EXP_W-1:0] sel_exp;
  logic             sel_sign;
  logic [LZ_W-1:0]  lead;
  logic [LZ_W-1:0]  shift;
  logic [LZ_W-1:0]  shamt;
  logic             is_zero;
  logic             clamp;

  always_comb begin
    stage_free = !out_valid_q || out_ready;
    grant      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    req_ready  = 2'b00;
    if (!rst && stage_free && (|req_valid)) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
    accept = |req_ready;
  end

  always_comb begin
    sel_man  = grant ? req_man[MAN_W +: MAN_W] : req_man[0 +: MAN_W];
    sel_exp  = grant ? req_exp[EXP_W +: EXP_W] : req_exp[0 +: EXP_W];
    sel_sign = req_sign[grant];
  end

  find_first_1 #(
    .IN_WIDTH  (MAN_W),
    .OUT_WIDTH (LZ_W)
  ) u_ff1 (
    .in_i    (sel_man),
    .first_o (lead)
  );

  always_comb begin
    is_zero = (lead == '1);
    shift   = LZ_W'(MAN_W - 1) - lead;
    clamp   = !is_zero && (32'(shift) >= 32'(sel_exp));
    // When clamping, exp <= shift < MAN_W so it fits the shift-amount width.
    shamt   = clamp ? LZ_W'(sel_exp) : shift;

    res_d      = '0;
    res_d.sign = sel_sign;
    res_d.src  = grant;
    if (is_zero) begin
      res_d.zero = 1'b1;
    end else begin
      res_d.man = sel_man << shamt;
      res_d.exp = clamp ? '0 : sel_exp - EXP_W'(shift);
      res_d.uf  = clamp;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
      res_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      if (accept) res_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_man   = res_q.man;
  assign out_exp   = res_q.exp;
  assign out_sign  = res_q.sign;
  assign out_src   = res_q.src;
  assign out_zero  = res_q.zero;
  assign out_uf    = res_q.uf;

endmodule

// File: tb/tb_norm_arbiter.sv
// Directed bench for norm_arbiter: vector table plus arbitration/backpressure/reset sequences.
module tb_norm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [53:0] req_man;
  logic [15:0] req_exp;
  logic [1:0]  req_sign;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_man;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_src;
  logic        out_zero;
  logic        out_uf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  norm_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_man   (req_man),
    .req_exp   (req_exp),
    .req_sign  (req_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_man   (out_man),
    .out_exp   (out_exp),
    .out_sign  (out_sign),
    .out_src   (out_src),
    .out_zero  (out_zero),
    .out_uf    (out_uf)
  );

  typedef struct {
    logic        src;
    logic [26:0] man;
    logic [7:0]  ex;
    logic        sign;
    logic [26:0] e_man;
    logic [7:0]  e_exp;
    logic        e_zero;
    logic        e_uf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic src, input logic [26:0] man, input logic [7:0] ex,
                         input logic sign);
    req_man[src*27 +: 27] = man;
    req_exp[src*8 +: 8]   = ex;
    req_sign[src]         = sign;
    req_valid[src]        = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [26:0] m, input logic [7:0] e,
                           input logic s, input logic src, input logic z, input logic u);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".man"},   32'(out_man),   32'(m));
    check({tag, ".exp"},   32'(out_exp),   32'(e));
    check({tag, ".sign"},  32'(out_sign),  32'(s));
    check({tag, ".src"},   32'(out_src),   32'(src));
    check({tag, ".zero"},  32'(out_zero),  32'(z));
    check({tag, ".uf"},    32'(out_uf),    32'(u));
  endtask

  initial begin
    // src, man, exp, sign -> man, exp, zero, uf
    vecs[0] = '{1'b0, 27'h0001000, 8'd100, 1'b0, 27'h4000000, 8'd86,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 27'h0000000, 8'd50,  1'b1, 27'h0000000, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{1'b0, 27'h0100000, 8'd4,   1'b0, 27'h1000000, 8'd0,   1'b0, 1'b1};
    vecs[3] = '{1'b1, 27'h4000000, 8'd10,  1'b1, 27'h4000000, 8'd10,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 27'h0000001, 8'd200, 1'b0, 27'h4000000, 8'd174, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 27'h5555555, 8'd1,   1'b1, 27'h5555555, 8'd1,   1'b0, 1'b0};
    vecs[6] = '{1'b0, 27'h0000003, 8'd25,  1'b0, 27'h6000000, 8'd0,   1'b0, 1'b1};
    vecs[7] = '{1'b1, 27'h0000003, 8'd26,  1'b0, 27'h6000000, 8'd1,   1'b0, 1'b0};
    vecs[8] = '{1'b0, 27'h0000800, 8'd0,   1'b1, 27'h0000800, 8'd0,   1'b0, 1'b1};
    vecs[9] = '{1'b1, 27'h0000000, 8'd0,   1'b0, 27'h0000000, 8'd0,   1'b1, 1'b0};

    rst       = 1'b1;
    req_valid = 2'b00;
    req_man   = '0;
    req_exp   = '0;
    req_sign  = 2'b00;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.man",   32'(out_man),   32'd0);
    check("rst.exp",   32'(out_exp),   32'd0);
    check("rst.src",   32'(out_src),   32'd0);
    req_valid = 2'b01;
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;

    // Table of single requests, one per cycle
    foreach (vecs[i]) begin
      set_req(vecs[i].src, vecs[i].man, vecs[i].ex, vecs[i].sign);
      #1;
      check($sformatf("v%0d.req_ready", i), 32'(req_ready), vecs[i].src ? 32'd2 : 32'd1);
      tick();
      req_valid = 2'b00;
      check_out($sformatf("v%0d", i), vecs[i].e_man, vecs[i].e_exp, vecs[i].sign,
                vecs[i].src, vecs[i].e_zero, vecs[i].e_uf);
    end
    tick();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Contention straight after reset: requester 0 wins the first tie
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 27'h4000000, 8'd5, 1'b0);
    set_req(1'b1, 27'h2000000, 8'd9, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d.req_ready", k), 32'(req_ready), (k % 2) ? 32'd2 : 32'd1);
      tick();
      check($sformatf("rr%0d.valid", k), 32'(out_valid), 32'd1);
      check($sformatf("rr%0d.src", k), 32'(out_src), 32'(k % 2));
      check($sformatf("rr%0d.exp", k), 32'(out_exp), (k % 2) ? 32'd8 : 32'd5);
    end
    req_valid = 2'b00;
    tick();

    // Backpressure: result held, no grants, then drain and accept in one cycle
    set_req(1'b0, 27'h0000010, 8'd30, 1'b1);
    tick();
    req_valid = 2'b00;
    out_ready = 1'b0;
    set_req(1'b1, 27'h0000100, 8'd40, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.req_ready", k), 32'(req_ready), 32'd0);
      check_out($sformatf("bp%0d", k), 27'h4000000, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.req_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    check_out("bp.new", 27'h4000000, 8'd22, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset while a result is held
    out_ready = 1'b0;
    set_req(1'b1, 27'h0000002, 8'd60, 1'b1);
    tick();
    req_valid = 2'b00;
    check("mid.valid_before", 32'(out_valid), 32'd1);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mid.rst.req_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("mid.valid_after", 32'(out_valid), 32'd0);
    check("mid.man_after",   32'(out_man),   32'd0);
    out_ready = 1'b1;
    set_req(1'b0, 27'h0000001, 8'd100, 1'b0);
    set_req(1'b1, 27'h0000001, 8'd100, 1'b1);
    #1;
    check("mid.tie.req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    check_out("mid.tie", 27'h4000000, 8'd74, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/norm_arbiter.md
# norm_arbiter

Round-robin scheduler that shares one leading-one detector and normalizing left-shifter between two floating-point requesters: port 0 (add/sub) and port 1 (multiply). Each accepted request is normalized so that its leading 1 lands at the mantissa MSB, with the exponent reduced accordingly. Results leave through a single registered valid/ready output tagged with the source port. The block sits between the arithmetic units and the shared rounding stage.

## Interface
- MAN_W, 27, mantissa width including guard/round/sticky bits
- EXP_W, 8, biased exponent width
- LZ_W, $clog2(MAN_W)+1, leading-one index width; all-ones means zero input
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  2  request valid, bit r for requester r
- req_ready  out  2  request accepted this cycle, bit r for requester r
- req_man  in  2*MAN_W  mantissas; requester r occupies bits [r*MAN_W +: MAN_W]
- req_exp  in  2*EXP_W  biased exponents, packed the same way
- req_sign  in  2  sign per requester, passed through unchanged
- out_valid  out  1  normalized result valid
- out_ready  in  1  downstream accepts the result
- out_man  out  MAN_W  normalized mantissa
- out_exp  out  EXP_W  adjusted exponent
- out_sign  out  1  sign of the source request
- out_src  out  1  granted requester index
- out_zero  out  1  input mantissa was zero
- out_uf  out  1  shift clamped by the exponent (subnormal result)

## Operation
- Stage is free when `out_valid`=0 or `out_valid && out_ready`.
- Grant:
  - Only when the stage is free.
  - One requester valid: grant it.
  - Both valid: grant the requester not in `last_grant`.
  - `req_ready[r]`=1 only for the granted r. At most one bit of `req_ready` is high.
  - `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `last_grant`.
  - `last_grant` updates only on an accepted transfer.
- Datapath, applied to the granted mantissa, combinational before the output register:
  - `lead` = index of the highest set bit, or all-ones if the mantissa is zero.
  - `shift` = MAN_W-1-`lead`, range 0..MAN_W-1.
- Zero mantissa: `out_man`=0, `out_exp`=0, `out_zero`=1, `out_uf`=0.
- Exponent clamp (`shift` >= `exp`, nonzero mantissa):
  - Shift by `exp` instead of `shift`.
  - `out_exp`=0, `out_uf`=1.
- Otherwise: `out_man` = `man` << `shift`, `out_exp` = `exp` - `shift`, `out_uf`=0.
- Output register:
  - Loads on accept.
  - Holds all fields while `out_valid && !out_ready`.
  - Clears `out_valid` on a drain with no new accept.
- Sign passes through unchanged. Exponent arithmetic is unsigned EXP_W bits; it cannot underflow because of the clamp.

## Timing
- Latency: accept in cycle N gives `out_valid`=1 in cycle N+1.
- Throughput: one result per cycle while `out_ready`=1. Simultaneous drain and accept in the same cycle is required.
- Requester rule: once asserted, `req_valid` and its data stay stable until `req_ready`. The arbiter never withdraws a pending grant in favor of the other port.
- Reset values: `out_valid`=0, all output data fields 0, `last_grant`=1 (requester 0 wins the first tie), `req_ready`=0 during `rst`.
- Reset mid-operation: a held result is discarded. `out_valid` is 0 in the cycle after `rst` is sampled high.
- Backpressure: while `out_valid && !out_ready`, `req_ready`=2'b00.

## Structure
- Shared FP package holds MAN_W, EXP_W, LZ_W and a packed struct `norm_res_t` {man, exp, sign, src, zero, uf}. The output register is declared as this struct.
- Sub-module: one find_first_1 instance with IN_WIDTH=MAN_W. Its output is the leading-one index, with all-ones for zero.
- The arbiter, shifter, clamp logic and output register stay in this module.

## Test plan
- Single request: req0, man=27'h0001000, exp=100 -> next cycle `out_valid`=1, `out_man`=27'h4000000, `out_exp`=86, `out_src`=0, `out_zero`=0, `out_uf`=0.
- Contention: both requesters valid continuously after reset, `out_ready`=1 -> grants alternate 0,1,0,1, one result per cycle.
- Zero: req1, man=0, exp=50 -> `out_man`=0, `out_exp`=0, `out_zero`=1, `out_src`=1.
- Clamp: req0, man=27'h0100000 (bit 20, shift 6), exp=4 -> `out_man`=27'h1000000, `out_exp`=0, `out_uf`=1.
- Backpressure: `out_ready`=0 for 3 cycles with `out_valid`=1 -> output stable, `req_ready`=0. Raise `out_ready` -> drain and a new accept in the same cycle.
- Reset: assert `rst` for one cycle while `out_valid`=1 -> `out_valid`=0 next cycle. The next tie grants requester 0.
